// File: rtl/hazard_unit_pkg.sv
// ---------------------------------------------------------------------------
// hazard_unit_pkg: shared state encoding and trap-index width.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package hazard_unit_pkg;

  localparam int TRAP_STAGE_W = 3;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_HALTED   = 2'd3
  } hazard_state_e;

endpackage

`default_nettype wire

// File: rtl/hazard_priority_encoder.sv
// ---------------------------------------------------------------------------
// hazard_priority_encoder: picks the oldest (highest-index) requesting stage.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_priority_encoder
  import hazard_unit_pkg::*;
#(
  parameter int NUM_STAGES = 3
) (
  input  logic [NUM_STAGES-1:0]   req,
  output logic                    valid,
  output logic [TRAP_STAGE_W-1:0] idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      if (req[s]) begin
        valid = 1'b1;
        idx   = TRAP_STAGE_W'(s);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/nspp_hazard_unit.sv
// ---------------------------------------------------------------------------
// nspp_hazard_unit: pipeline stall/flush control, trap drain and redirect.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module nspp_hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int BR_STAGE   = 1,
  parameter int WORD_W     = 32
) (
  input  logic                               CLK,
  input  logic                               nRST,
  input  logic                               i_mem_busy,
  input  logic                               d_mem_busy,
  input  logic                               mispredict,
  input  logic                               jump,
  input  logic                               ret,
  input  logic                               halt,
  input  logic                               fence_stall,
  input  logic [NUM_STAGES-1:0]              exc_valid,
  input  logic [NUM_STAGES-1:0][WORD_W-1:0]  exc_epc,
  input  logic [NUM_STAGES-1:0][WORD_W-1:0]  exc_badaddr,
  output logic [NUM_STAGES-1:0]              stage_stall,
  output logic [NUM_STAGES-1:0]              stage_flush,
  output logic                               pc_en,
  output logic                               npc_sel,
  output logic                               iren,
  output logic                               insert_priv_pc,
  output logic [WORD_W-1:0]                  epc_out,
  output logic [WORD_W-1:0]                  badaddr_out,
  output logic [TRAP_STAGE_W-1:0]            trap_stage,
  output logic [31:0]                        stall_cycles
);

  hazard_state_e             state_q, state_d;
  logic [WORD_W-1:0]         epc_q, epc_d;
  logic [WORD_W-1:0]         badaddr_q, badaddr_d;
  logic [TRAP_STAGE_W-1:0]   trap_stage_q, trap_stage_d;
  logic [31:0]               stall_cycles_q, stall_cycles_d;
  logic                      halt_pend_q, halt_pend_d;

  logic                      exc_hit;
  logic [TRAP_STAGE_W-1:0]   exc_idx;
  logic [WORD_W-1:0]         exc_epc_sel;
  logic [WORD_W-1:0]         exc_bad_sel;
  logic                      branch;
  logic                      hold_older;
  int                        flush_lim;

  hazard_priority_encoder #(
    .NUM_STAGES (NUM_STAGES)
  ) u_prio (
    .req   (exc_valid),
    .valid (exc_hit),
    .idx   (exc_idx)
  );

  always_comb begin
    exc_epc_sel = '0;
    exc_bad_sel = '0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      if (int'(exc_idx) == s) begin
        exc_epc_sel = exc_epc[s];
        exc_bad_sel = exc_badaddr[s];
      end
    end
  end

  assign branch = mispredict | jump;

  always_comb begin
    state_d        = state_q;
    epc_d          = epc_q;
    badaddr_d      = badaddr_q;
    trap_stage_d   = trap_stage_q;
    halt_pend_d    = halt_pend_q;
    stall_cycles_d = stall_cycles_q;
    stage_stall    = '0;
    stage_flush    = '0;
    pc_en          = 1'b1;
    npc_sel        = 1'b0;
    iren           = 1'b1;
    insert_priv_pc = 1'b0;
    flush_lim      = -1;
    hold_older     = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (halt) begin
          stage_stall = '1;
          pc_en       = 1'b0;
          state_d     = ST_HALTED;
        end else if (d_mem_busy) begin
          stage_stall = '1;
          pc_en       = 1'b0;
        end else if (exc_hit && !((int'(exc_idx) < BR_STAGE) && branch)) begin
          // Younger-than-branch exceptions under a redirect are wrong-path and dropped above.
          epc_d        = exc_epc_sel;
          badaddr_d    = exc_bad_sel;
          trap_stage_d = exc_idx;
          flush_lim    = int'(exc_idx);
          pc_en        = 1'b0;
          state_d      = ST_DRAIN;
        end else if (ret) begin
          epc_d        = '0;
          badaddr_d    = '0;
          trap_stage_d = TRAP_STAGE_W'(BR_STAGE);
          flush_lim    = BR_STAGE;
          pc_en        = 1'b0;
          state_d      = ST_DRAIN;
        end else if (branch) begin
          npc_sel   = 1'b1;
          flush_lim = BR_STAGE - 1;
        end else if (fence_stall) begin
          pc_en = 1'b0;
          // Stage behind the held group gets a bubble so nothing is issued twice.
          for (int s = 0; s < NUM_STAGES; s++) begin
            if (s <= BR_STAGE)     stage_stall[s] = 1'b1;
            if (s == BR_STAGE + 1) stage_flush[s] = 1'b1;
          end
        end else if (i_mem_busy) begin
          pc_en          = 1'b0;
          stage_stall[0] = 1'b1;
          stage_flush[1] = 1'b1;
        end
      end

      ST_DRAIN: begin
        pc_en     = 1'b0;
        flush_lim = int'(trap_stage_q);
        if (exc_hit && (exc_idx > trap_stage_q)) begin
          epc_d        = exc_epc_sel;
          badaddr_d    = exc_bad_sel;
          trap_stage_d = exc_idx;
          flush_lim    = int'(exc_idx);
        end
        hold_older = d_mem_busy;
        if (halt) halt_pend_d = 1'b1;
        if (!i_mem_busy && !d_mem_busy) state_d = ST_REDIRECT;
      end

      ST_REDIRECT: begin
        insert_priv_pc = 1'b1;
        stage_flush    = '1;
        halt_pend_d    = 1'b0;
        state_d        = (halt || halt_pend_q) ? ST_HALTED : ST_RUN;
      end

      ST_HALTED: begin
        stage_stall = '1;
        pc_en       = 1'b0;
        iren        = 1'b0;
      end

      default: state_d = ST_RUN;
    endcase

    for (int s = 0; s < NUM_STAGES; s++) begin
      if (s <= flush_lim)               stage_flush[s] = 1'b1;
      if (hold_older && s > flush_lim)  stage_stall[s] = 1'b1;
    end

    if (!pc_en && (state_q != ST_HALTED) && (stall_cycles_q != 32'hFFFF_FFFF))
      stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q        <= ST_RUN;
      epc_q          <= '0;
      badaddr_q      <= '0;
      trap_stage_q   <= '0;
      stall_cycles_q <= '0;
      halt_pend_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      epc_q          <= epc_d;
      badaddr_q      <= badaddr_d;
      trap_stage_q   <= trap_stage_d;
      stall_cycles_q <= stall_cycles_d;
      halt_pend_q    <= halt_pend_d;
    end
  end

  assign epc_out      = epc_q;
  assign badaddr_out  = badaddr_q;
  assign trap_stage   = trap_stage_q;
  assign stall_cycles = stall_cycles_q;

endmodule

`default_nettype wire
